// File: rtl/dep_matrix_scheduler_pkg.sv
// rtl/dep_matrix_scheduler_pkg.sv - shared types and helpers for the dependency-matrix scheduler
// Purpose: entry state encoding and the k-th free entry finder used for allocation.
// Ports: none (package).
package dep_matrix_scheduler_pkg;

   // Widest entry vector the allocation helper can scan; narrower callers zero-extend.
   localparam int MAX_ENTRIES = 64;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      WAIT   = 2'd1,
      ISSUED = 2'd2
   } sched_state_t;

   // Index of the k-th (0-based) lowest set bit of vec; 0 when fewer than k+1 bits are set.
   function automatic int unsigned kth_set_idx(input logic [MAX_ENTRIES-1:0] vec,
                                               input int unsigned k);
      int unsigned seen;
      int unsigned idx;
      logic        found;
      seen  = 0;
      idx   = 0;
      found = 1'b0;
      for (int i = 0; i < MAX_ENTRIES; i++) begin
         if (vec[i] && !found) begin
            if (seen == k) begin
               idx   = unsigned'(i);
               found = 1'b1;
            end
            seen++;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sched_age_select.sv
// rtl/sched_age_select.sv - combinational oldest-ready picker driven by an age matrix
// Purpose: picks the ready entry that has no older ready entry.
// Ports: ready_i (ready vector), older_i (row i = entries older than i),
//        valid_o (any entry ready), idx_o (selected entry, 0 when none).
module sched_age_select #(
   parameter int  N     = 8,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]        ready_i,
   input  logic [N-1:0][N-1:0] older_i,
   output logic                valid_o,
   output logic [IDX_W-1:0]    idx_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      // The age matrix is a strict order over live entries, so at most one match.
      for (int i = 0; i < N; i++) begin
         if (ready_i[i] && ((older_i[i] & ready_i) == '0)) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/dep_matrix_scheduler.sv
// rtl/dep_matrix_scheduler.sv - wakeup/select scheduler for one FU issue port
// Purpose: allocates up to DISPATCH_W entries per cycle, tracks producer dependencies in an
//          entry-indexed matrix, issues the oldest ready entry and wakes dependants
//          WAKEUP_LAT cycles after issue acceptance.
// Ports: clk, rst_n (async active-low), flush (sync kill of all entries),
//        disp_valid/disp_deps (dispatch requests), disp_ready/alloc_idx (allocation),
//        issue_valid/issue_idx/issue_ready (issue handshake), wakeup_vec (columns cleared
//        at the coming edge), free_count (number of FREE entries).
module dep_matrix_scheduler
   import dep_matrix_scheduler_pkg::*;
#(
   parameter int  NUM_ENTRIES = 8,
   parameter int  DISPATCH_W  = 2,
   parameter int  WAKEUP_LAT  = 1,
   localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   flush,
   input  logic [DISPATCH_W-1:0]                  disp_valid,
   input  logic [DISPATCH_W-1:0][NUM_ENTRIES-1:0] disp_deps,
   output logic [DISPATCH_W-1:0]                  disp_ready,
   output logic [DISPATCH_W-1:0][IDX_W-1:0]       alloc_idx,
   output logic                                   issue_valid,
   output logic [IDX_W-1:0]                       issue_idx,
   input  logic                                   issue_ready,
   output logic [NUM_ENTRIES-1:0]                 wakeup_vec,
   output logic [IDX_W:0]                         free_count
);

   localparam int CNT_W = (WAKEUP_LAT > 1) ? $clog2(WAKEUP_LAT) : 1;

   sched_state_t                           state_q [NUM_ENTRIES];
   sched_state_t                           state_d [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] dep_q, dep_d;
   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;

   logic [NUM_ENTRIES-1:0] free_vec;
   logic [NUM_ENTRIES-1:0] live_vec;
   logic [NUM_ENTRIES-1:0] ready_vec;
   logic [NUM_ENTRIES-1:0] wake_vec;
   logic [DISPATCH_W-1:0]  disp_acc;
   logic                   issue_fire;

   always_comb begin
      free_vec   = '0;
      ready_vec  = '0;
      free_count = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         free_vec[i]  = (state_q[i] == FREE);
         ready_vec[i] = (state_q[i] == WAIT) && (dep_q[i] == '0);
         free_count   = free_count + (IDX_W+1)'(free_vec[i]);
      end
      live_vec = ~free_vec;
   end

   always_comb begin
      alloc_idx  = '0;
      disp_ready = '0;
      for (int k = 0; k < DISPATCH_W; k++) begin
         alloc_idx[k]  = IDX_W'(kth_set_idx(MAX_ENTRIES'(free_vec), unsigned'(k)));
         disp_ready[k] = (free_count > (IDX_W+1)'(k));
      end
   end

   sched_age_select #(.N(NUM_ENTRIES)) u_age_select (
      .ready_i (ready_vec),
      .older_i (older_q),
      .valid_o (issue_valid),
      .idx_o   (issue_idx)
   );

   assign issue_fire = issue_valid & issue_ready;
   assign disp_acc   = disp_valid & disp_ready;
   assign wakeup_vec = wake_vec;

   // Per-entry wakeup counters: loaded on issue, wake when they reach zero while ISSUED.
   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_wake_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign wake_vec[g] = (state_q[g] == ISSUED) && (cnt_q == '0);

      always_comb begin
         cnt_d = cnt_q;
         if (issue_fire && (issue_idx == IDX_W'(g))) begin
            cnt_d = CNT_W'(WAKEUP_LAT - 1);
         end else if ((state_q[g] == ISSUED) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (flush) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   always_comb begin : p_next
      logic [NUM_ENTRIES-1:0] alloc_mask;
      state_d    = state_q;
      dep_d      = dep_q;
      older_d    = older_q;
      alloc_mask = '0;

      // Wakeups: clear the producer column everywhere and release the entry.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         dep_d[i]   = dep_q[i] & ~wake_vec;
         older_d[i] = older_q[i] & ~wake_vec;
         if (wake_vec[i]) begin
            state_d[i] = FREE;
            dep_d[i]   = '0;
            older_d[i] = '0;
         end
      end

      if (issue_fire) begin
         state_d[issue_idx] = ISSUED;
      end

      // Lower slots are older than higher slots in the same dispatch group, and may be
      // named as producers; entries waking at this edge are already resolved.
      for (int k = 0; k < DISPATCH_W; k++) begin
         if (disp_acc[k]) begin
            state_d[alloc_idx[k]] = WAIT;
            dep_d[alloc_idx[k]]   = disp_deps[k] & (live_vec | alloc_mask) & ~wake_vec;
            older_d[alloc_idx[k]] = (live_vec | alloc_mask) & ~wake_vec;
            alloc_mask[alloc_idx[k]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i] <= FREE;
         end
         dep_q   <= '0;
         older_q <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i] <= FREE;
         end
         dep_q   <= '0;
         older_q <= '0;
      end else begin
         state_q <= state_d;
         dep_q   <= dep_d;
         older_q <= older_d;
      end
   end

endmodule

// File: tb/tb_dep_matrix_scheduler.sv
// tb/tb_dep_matrix_scheduler.sv - self-checking bench for dep_matrix_scheduler
module tb_dep_matrix_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   logic [1:0]      disp_valid;
   logic [1:0][7:0] disp_deps;
   logic [1:0]      disp_ready;
   logic [1:0][2:0] alloc_idx;
   logic            issue_valid;
   logic [2:0]      issue_idx;
   logic            issue_ready;
   logic [7:0]      wakeup_vec;
   logic [3:0]      free_count;

   logic [1:0]      disp_valid3;
   logic [1:0][7:0] disp_deps3;
   logic [1:0]      disp_ready3;
   logic [1:0][2:0] alloc_idx3;
   logic            issue_valid3;
   logic [2:0]      issue_idx3;
   logic            issue_ready3;
   logic [7:0]      wakeup_vec3;
   logic [3:0]      free_count3;

   int checks;
   int failures;
   int sb[$];

   always #5 clk = ~clk;

   dep_matrix_scheduler #(.NUM_ENTRIES(8), .DISPATCH_W(2), .WAKEUP_LAT(1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .disp_valid  (disp_valid),
      .disp_deps   (disp_deps),
      .disp_ready  (disp_ready),
      .alloc_idx   (alloc_idx),
      .issue_valid (issue_valid),
      .issue_idx   (issue_idx),
      .issue_ready (issue_ready),
      .wakeup_vec  (wakeup_vec),
      .free_count  (free_count)
   );

   dep_matrix_scheduler #(.NUM_ENTRIES(8), .DISPATCH_W(2), .WAKEUP_LAT(3)) u_dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .disp_valid  (disp_valid3),
      .disp_deps   (disp_deps3),
      .disp_ready  (disp_ready3),
      .alloc_idx   (alloc_idx3),
      .issue_valid (issue_valid3),
      .issue_idx   (issue_idx3),
      .issue_ready (issue_ready3),
      .wakeup_vec  (wakeup_vec3),
      .free_count  (free_count3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compares any issue handshake of the LAT=1 instance against the scoreboard, then
   // advances to just after the next rising edge.
   task automatic tick();
      if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("issue_unexpected", 32'(issue_idx), 32'hFFFF_FFFF);
         end else begin
            int e;
            e = sb.pop_front();
            chk("issue_order", 32'(issue_idx), e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      flush        = 1'b0;
      disp_valid   = '0;
      disp_deps    = '0;
      issue_ready  = 1'b0;
      disp_valid3  = '0;
      disp_deps3   = '0;
      issue_ready3 = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 0);
      chk("rst_issue_idx", 32'(issue_idx), 0);
      chk("rst_wakeup_vec", 32'(wakeup_vec), 0);
      chk("rst_free_count", 32'(free_count), 8);
      chk("rst_disp_ready", 32'(disp_ready), 2'b11);
      chk("rst_free_count3", 32'(free_count3), 8);
      rst_n = 1'b1;
      tick();

      // Two independent dispatches, back-to-back issue, return to empty
      disp_valid  = 2'b11;
      disp_deps   = '0;
      issue_ready = 1'b1;
      chk("t1_alloc0", 32'(alloc_idx[0]), 0);
      chk("t1_alloc1", 32'(alloc_idx[1]), 1);
      sb.push_back(0);
      sb.push_back(1);
      tick();
      disp_valid = '0;
      chk("t1_valid", 32'(issue_valid), 1);
      chk("t1_idx_oldest", 32'(issue_idx), 0);
      chk("t1_free6", 32'(free_count), 6);
      tick();
      chk("t1_idx_next", 32'(issue_idx), 1);
      chk("t1_wake0", 32'(wakeup_vec), 8'h01);
      tick();
      chk("t1_free7", 32'(free_count), 7);
      chk("t1_wake1", 32'(wakeup_vec), 8'h02);
      chk("t1_idle", 32'(issue_valid), 0);
      tick();
      chk("t1_free8", 32'(free_count), 8);
      issue_ready = 1'b0;

      // Same-cycle chain; A's dep on FREE entry 7 is ignored
      disp_valid   = 2'b11;
      disp_deps[0] = 8'h80;
      disp_deps[1] = 8'h01;
      tick();
      disp_valid = '0;
      disp_deps  = '0;
      chk("chain_a_ready", 32'(issue_valid), 1);
      chk("chain_a_idx", 32'(issue_idx), 0);
      issue_ready = 1'b1;
      sb.push_back(0);
      tick();
      chk("chain_b_blocked", 32'(issue_valid), 0);
      chk("chain_wake_a", 32'(wakeup_vec), 8'h01);
      sb.push_back(1);
      tick();
      chk("chain_b_ready", 32'(issue_valid), 1);
      chk("chain_b_idx", 32'(issue_idx), 1);
      tick();
      chk("chain_wake_b", 32'(wakeup_vec), 8'h02);
      tick();
      chk("chain_free8", 32'(free_count), 8);
      issue_ready = 1'b0;

      // Stalled FU: oldest ready entry held, newer ready entry does not preempt
      disp_valid = 2'b01;
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", 32'(issue_valid), 1);
         chk("hold_idx", 32'(issue_idx), 0);
         disp_valid = (c == 2) ? 2'b01 : 2'b00;
         tick();
      end
      disp_valid  = '0;
      issue_ready = 1'b1;
      sb.push_back(0);
      sb.push_back(1);
      sb.push_back(2);
      repeat (4) tick();
      chk("hold_free8", 32'(free_count), 8);
      issue_ready = 1'b0;

      // Fill every entry behind a never-issued producer in entry 0
      disp_valid   = 2'b11;
      disp_deps[0] = 8'h00;
      disp_deps[1] = 8'h01;
      chk("fill_alloc0_r0", 32'(alloc_idx[0]), 0);
      tick();
      disp_deps[0] = 8'h01;
      for (int r = 1; r < 4; r++) begin
         chk("fill_alloc0", 32'(alloc_idx[0]), 2 * r);
         chk("fill_alloc1", 32'(alloc_idx[1]), 2 * r + 1);
         tick();
      end
      chk("full_free0", 32'(free_count), 0);
      chk("full_disp_ready", 32'(disp_ready), 0);
      tick();
      disp_valid = '0;
      disp_deps  = '0;
      chk("full_ignored_free", 32'(free_count), 0);
      chk("full_only_p_ready", 32'(issue_valid), 1);
      chk("full_p_idx", 32'(issue_idx), 0);

      // Flush with one entry ISSUED and seven WAIT
      issue_ready = 1'b1;
      sb.push_back(0);
      tick();
      chk("pre_flush_wake", 32'(wakeup_vec), 8'h01);
      chk("pre_flush_blocked", 32'(issue_valid), 0);
      issue_ready = 1'b0;
      flush       = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_free8", 32'(free_count), 8);
      chk("flush_no_issue", 32'(issue_valid), 0);
      chk("flush_no_wake", 32'(wakeup_vec), 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_flush_wake", 32'(wakeup_vec), 0);
         chk("post_flush_free", 32'(free_count), 8);
      end

      // WAKEUP_LAT=3 instance: B depends on A, appears three edges after A's issue
      disp_valid3    = 2'b11;
      disp_deps3[0]  = 8'h00;
      disp_deps3[1]  = 8'h01;
      tick();
      disp_valid3 = '0;
      disp_deps3  = '0;
      chk("lat3_a_valid", 32'(issue_valid3), 1);
      chk("lat3_a_idx", 32'(issue_idx3), 0);
      issue_ready3 = 1'b1;
      tick();
      chk("lat3_t1_valid", 32'(issue_valid3), 0);
      chk("lat3_t1_wake", 32'(wakeup_vec3), 0);
      tick();
      chk("lat3_t2_valid", 32'(issue_valid3), 0);
      chk("lat3_t2_wake", 32'(wakeup_vec3), 0);
      tick();
      chk("lat3_t3_valid", 32'(issue_valid3), 0);
      chk("lat3_t3_wake", 32'(wakeup_vec3), 8'h01);
      tick();
      chk("lat3_b_valid", 32'(issue_valid3), 1);
      chk("lat3_b_idx", 32'(issue_idx3), 1);
      tick();
      issue_ready3 = 1'b0;
      repeat (3) tick();
      chk("lat3_free8", 32'(free_count3), 8);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
